// File: rtl/adc_spi_rx12.sv
// SPI master that captures one 12-bit ADC sample per start strobe: a 16-SCLK frame
// (4 leading zeros, then D11..D0 MSB first) followed by a quiet gap with NCS high.
module adc_spi_rx12 #(
   parameter int SCLK_DIV = 1,
   parameter int Q_CLKS   = 2
) (
   input  logic        i_clk,
   input  logic        i_nrst,
   input  logic        i_st,
   input  logic        i_sdata,
   output logic        o_ncs,
   output logic        o_sclk,
   output logic [11:0] o_do,
   output logic        o_ok,
   output logic        o_err,
   output logic        o_busy
);

   localparam int DIV_W = (SCLK_DIV > 2) ? $clog2(SCLK_DIV) : 1;
   localparam int Q_W   = (Q_CLKS > 2) ? $clog2(Q_CLKS - 1) : 1;
   localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(SCLK_DIV - 1);
   localparam logic [Q_W-1:0]   Q_LAST     = Q_W'((Q_CLKS >= 2) ? Q_CLKS - 2 : 0);

   typedef enum logic [1:0] {S_IDLE, S_FRAME, S_QUIET} state_t;

   state_t           r_state, w_state_nxt;
   logic [DIV_W-1:0] r_div, w_div_nxt;
   logic [4:0]       r_bit, w_bit_nxt;
   logic [15:0]      r_shift, w_shift_nxt;
   logic [Q_W-1:0]   r_q, w_q_nxt;
   logic             r_ncs, w_ncs_nxt;
   logic             r_sclk, w_sclk_nxt;
   logic [11:0]      r_do, w_do_nxt;
   logic             r_ok, w_ok_nxt;
   logic             r_err, w_err_nxt;
   logic             r_busy, w_busy_nxt;

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         r_state <= S_IDLE;
         r_div   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_q     <= '0;
         r_ncs   <= 1'b1;
         r_sclk  <= 1'b1;
         r_do    <= '0;
         r_ok    <= 1'b0;
         r_err   <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_div   <= w_div_nxt;
         r_bit   <= w_bit_nxt;
         r_shift <= w_shift_nxt;
         r_q     <= w_q_nxt;
         r_ncs   <= w_ncs_nxt;
         r_sclk  <= w_sclk_nxt;
         r_do    <= w_do_nxt;
         r_ok    <= w_ok_nxt;
         r_err   <= w_err_nxt;
         r_busy  <= w_busy_nxt;
      end
   end

   // The half-period down-counter starts at zero, so the first tick after the start
   // edge is a lead-in that only drops SCLK for bit 0.
   always_comb begin
      w_state_nxt = r_state;
      w_div_nxt   = r_div;
      w_bit_nxt   = r_bit;
      w_shift_nxt = r_shift;
      w_q_nxt     = r_q;
      w_ncs_nxt   = r_ncs;
      w_sclk_nxt  = r_sclk;
      w_do_nxt    = r_do;
      w_ok_nxt    = 1'b0;
      w_err_nxt   = r_err;
      w_busy_nxt  = r_busy;

      case (r_state)
         S_IDLE: begin
            if (i_st) begin
               w_state_nxt = S_FRAME;
               w_ncs_nxt   = 1'b0;
               w_busy_nxt  = 1'b1;
               w_bit_nxt   = '0;
               w_div_nxt   = '0;
               w_shift_nxt = '0;
            end
         end
         S_FRAME: begin
            if (r_div != '0) begin
               w_div_nxt = r_div - 1'b1;
            end else begin
               w_div_nxt = DIV_RELOAD;
               if (!r_sclk) begin
                  w_sclk_nxt  = 1'b1;
                  w_shift_nxt = {r_shift[14:0], i_sdata};
                  w_bit_nxt   = r_bit + 5'd1;
               end else if (r_bit != 5'd16) begin
                  w_sclk_nxt = 1'b0;
               end else begin
                  w_ncs_nxt = 1'b1;
                  w_do_nxt  = r_shift[11:0];
                  w_err_nxt = |r_shift[15:12];
                  w_ok_nxt  = 1'b1;
                  w_q_nxt   = '0;
                  if (Q_CLKS > 1) begin
                     w_state_nxt = S_QUIET;
                  end else begin
                     w_state_nxt = S_IDLE;
                     w_busy_nxt  = 1'b0;
                  end
               end
            end
         end
         S_QUIET: begin
            // The ok cycle already counts as the first quiet cycle.
            if (r_q == Q_LAST) begin
               w_state_nxt = S_IDLE;
               w_busy_nxt  = 1'b0;
            end else begin
               w_q_nxt = r_q + 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign o_ncs  = r_ncs;
   assign o_sclk = r_sclk;
   assign o_do   = r_do;
   assign o_ok   = r_ok;
   assign o_err  = r_err;
   assign o_busy = r_busy;

endmodule

// File: tb/tb_adc_spi_rx12.sv
// Testbench for adc_spi_rx12: two instances (default and slow timing), each fed by
// a behavioural serial ADC model; results compared against values computed here.
module tb_adc_spi_rx12;

   localparam int DIV_A = 1;
   localparam int Q_A   = 2;
   localparam int DIV_B = 3;
   localparam int Q_B   = 4;

   logic clk = 1'b0;
   logic nrst;
   logic stA, stB, sdataA, sdataB;
   logic ncsA, sclkA, okA, errA, busyA;
   logic ncsB, sclkB, okB, errB, busyB;
   logic [11:0] doA, doB;

   logic [15:0] wordA, wordB;
   int idxA, idxB;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   adc_spi_rx12 dutA (
      .i_clk(clk), .i_nrst(nrst), .i_st(stA), .i_sdata(sdataA),
      .o_ncs(ncsA), .o_sclk(sclkA), .o_do(doA), .o_ok(okA), .o_err(errA), .o_busy(busyA)
   );

   adc_spi_rx12 #(.SCLK_DIV(DIV_B), .Q_CLKS(Q_B)) dutB (
      .i_clk(clk), .i_nrst(nrst), .i_st(stB), .i_sdata(sdataB),
      .o_ncs(ncsB), .o_sclk(sclkB), .o_do(doB), .o_ok(okB), .o_err(errB), .o_busy(busyB)
   );

   // Serial ADC: a new frame starts when NCS falls; each SCLK fall presents the next bit.
   always @(negedge ncsA) idxA = 0;
   always @(negedge sclkA) if (!ncsA) begin
      sdataA = (idxA < 16) ? wordA[15 - idxA] : 1'b0;
      idxA++;
   end

   always @(negedge ncsB) idxB = 0;
   always @(negedge sclkB) if (!ncsB) begin
      sdataB = (idxB < 16) ? wordB[15 - idxB] : 1'b0;
      idxB++;
   end

   // Starts one frame on the selected instance and measures it until busy drops.
   task automatic runFrame(input bit sel, input logic [15:0] word,
                           output int lat, output int okCnt, output int ncsLow,
                           output int falls, output int minGap, output int maxGap,
                           output int busyCyc, output logic [11:0] doVal,
                           output logic errVal, output bit timedOut);
      int lastFall;
      logic prevS, ok, ncs, sclk, busy;
      lat = -1; okCnt = 0; ncsLow = 0; falls = 0; minGap = 1000; maxGap = 0;
      busyCyc = 0; doVal = 'x; errVal = 1'bx; timedOut = 1'b0; lastFall = -1;
      if (sel) wordB = word; else wordA = word;
      @(posedge clk); #1;
      if (sel) stB = 1'b1; else stA = 1'b1;
      @(posedge clk); #1;
      stA = 1'b0; stB = 1'b0;
      prevS = 1'b1;
      for (int n = 0; n <= 400; n++) begin
         if (n > 0) begin @(posedge clk); #1; end
         ok   = sel ? okB : okA;
         ncs  = sel ? ncsB : ncsA;
         sclk = sel ? sclkB : sclkA;
         busy = sel ? busyB : busyA;
         if (ok) begin
            okCnt++;
            if (lat < 0) begin
               lat = n;
               doVal = sel ? doB : doA;
               errVal = sel ? errB : errA;
            end
         end
         if (!ncs) ncsLow++;
         if (prevS && !sclk) begin
            falls++;
            if (lastFall >= 0) begin
               if (n - lastFall < minGap) minGap = n - lastFall;
               if (n - lastFall > maxGap) maxGap = n - lastFall;
            end
            lastFall = n;
         end
         prevS = sclk;
         if (!busy) break;
         busyCyc++;
         if (n == 400) timedOut = 1'b1;
      end
   endtask

   task automatic test_reset();
      nrst = 1'b0; stA = 1'b0; stB = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (ncsA !== 1'b1) begin errors++; $display("[TB] FAIL reset_ncs got %b exp 1", ncsA); end
      checks++; if (sclkA !== 1'b1) begin errors++; $display("[TB] FAIL reset_sclk got %b exp 1", sclkA); end
      checks++; if (doA !== 12'h000) begin errors++; $display("[TB] FAIL reset_do got %h exp 000", doA); end
      checks++; if (okA !== 1'b0) begin errors++; $display("[TB] FAIL reset_ok got %b exp 0", okA); end
      checks++; if (errA !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %b exp 0", errA); end
      checks++; if (busyA !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b exp 0", busyA); end
      @(negedge clk) nrst = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      checks++; if (ncsA !== 1'b1 || sclkA !== 1'b1) begin errors++; $display("[TB] FAIL hold_lines got ncs=%b sclk=%b exp 1/1", ncsA, sclkA); end
      checks++; if (busyA !== 1'b0 || okA !== 1'b0) begin errors++; $display("[TB] FAIL hold_busy_ok got busy=%b ok=%b exp 0/0", busyA, okA); end
      checks++; if (ncsB !== 1'b1 || sclkB !== 1'b1 || busyB !== 1'b0) begin errors++; $display("[TB] FAIL hold_b got ncs=%b sclk=%b busy=%b exp 1/1/0", ncsB, sclkB, busyB); end
   endtask

   task automatic test_single_frame();
      int lat, okCnt, ncsLow, falls, minGap, maxGap, busyCyc;
      logic [11:0] doVal; logic errVal; bit to;
      runFrame(1'b0, 16'h0A5C, lat, okCnt, ncsLow, falls, minGap, maxGap, busyCyc, doVal, errVal, to);
      checks++; if (to) begin errors++; $display("[TB] FAIL single_timeout got busy stuck exp release"); end
      checks++; if (lat != 1 + 32 * DIV_A) begin errors++; $display("[TB] FAIL single_latency got %0d exp %0d", lat, 1 + 32 * DIV_A); end
      checks++; if (okCnt != 1) begin errors++; $display("[TB] FAIL single_okcount got %0d exp 1", okCnt); end
      checks++; if (doVal !== 12'hA5C) begin errors++; $display("[TB] FAIL single_do got %h exp a5c", doVal); end
      checks++; if (errVal !== 1'b0) begin errors++; $display("[TB] FAIL single_err got %b exp 0", errVal); end
      checks++; if (falls != 16) begin errors++; $display("[TB] FAIL single_sclk_falls got %0d exp 16", falls); end
      // NCS drops on the start edge and rises together with ok.
      checks++; if (ncsLow != 1 + 32 * DIV_A) begin errors++; $display("[TB] FAIL single_ncs_low got %0d exp %0d", ncsLow, 1 + 32 * DIV_A); end
      checks++; if (busyCyc != 32 * DIV_A + Q_A) begin errors++; $display("[TB] FAIL single_busy got %0d exp %0d", busyCyc, 32 * DIV_A + Q_A); end
      checks++; if (minGap != 2 * DIV_A || maxGap != 2 * DIV_A) begin errors++; $display("[TB] FAIL single_sclk_period got %0d..%0d exp %0d", minGap, maxGap, 2 * DIV_A); end
   endtask

   task automatic test_frame_error();
      int lat, okCnt, ncsLow, falls, minGap, maxGap, busyCyc;
      logic [11:0] doVal; logic errVal; bit to;
      runFrame(1'b0, 16'h4FFF, lat, okCnt, ncsLow, falls, minGap, maxGap, busyCyc, doVal, errVal, to);
      checks++; if (to || doVal !== 12'hFFF) begin errors++; $display("[TB] FAIL err_frame_do got %h exp fff", doVal); end
      checks++; if (errVal !== 1'b1) begin errors++; $display("[TB] FAIL err_frame_err got %b exp 1", errVal); end
      repeat (5) @(posedge clk);
      #1;
      checks++; if (doA !== 12'hFFF || errA !== 1'b1) begin errors++; $display("[TB] FAIL err_hold got do=%h err=%b exp fff/1", doA, errA); end
      runFrame(1'b0, 16'h0000, lat, okCnt, ncsLow, falls, minGap, maxGap, busyCyc, doVal, errVal, to);
      checks++; if (to || lat != 1 + 32 * DIV_A) begin errors++; $display("[TB] FAIL clean_latency got %0d exp %0d", lat, 1 + 32 * DIV_A); end
      checks++; if (doVal !== 12'h000 || errVal !== 1'b0) begin errors++; $display("[TB] FAIL clean_frame got do=%h err=%b exp 000/0", doVal, errVal); end
   endtask

   task automatic test_back_to_back();
      int okTotal, okThis;
      logic [15:0] word;
      logic [3:0] lead;
      logic [11:0] expDo;
      logic expErr;
      okTotal = 0;
      for (int f = 0; f < 100; f++) begin
         lead = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
         word = {lead, 12'($urandom)};
         expDo = word[11:0];
         expErr = |word[15:12];
         wordA = word;
         okThis = 0;
         for (int c = 0; c < 50; c++) begin
            stA = (c == 0 || c == 5 || c == 34);
            @(posedge clk);
            #1;
            stA = 1'b0;
            if (okA) begin
               okTotal++;
               okThis++;
               checks++; if (c != 1 + 32 * DIV_A) begin errors++; $display("[TB] FAIL b2b_ok_cycle frame %0d got %0d exp %0d", f, c, 1 + 32 * DIV_A); end
               checks++; if (doA !== expDo) begin errors++; $display("[TB] FAIL b2b_do frame %0d got %h exp %h", f, doA, expDo); end
               checks++; if (errA !== expErr) begin errors++; $display("[TB] FAIL b2b_err frame %0d got %b exp %b", f, errA, expErr); end
            end
         end
         checks++; if (okThis != 1) begin errors++; $display("[TB] FAIL b2b_ok_per_frame frame %0d got %0d exp 1", f, okThis); end
      end
      checks++; if (okTotal != 100) begin errors++; $display("[TB] FAIL b2b_ok_total got %0d exp 100", okTotal); end
   endtask

   task automatic test_slow_config();
      int lat, okCnt, ncsLow, falls, minGap, maxGap, busyCyc;
      logic [11:0] doVal; logic errVal; bit to;
      logic [15:0] word;
      word = {4'h0, 12'($urandom)};
      runFrame(1'b1, word, lat, okCnt, ncsLow, falls, minGap, maxGap, busyCyc, doVal, errVal, to);
      checks++; if (to) begin errors++; $display("[TB] FAIL slow_timeout got busy stuck exp release"); end
      checks++; if (lat != 1 + 32 * DIV_B) begin errors++; $display("[TB] FAIL slow_latency got %0d exp %0d", lat, 1 + 32 * DIV_B); end
      checks++; if (minGap != 2 * DIV_B || maxGap != 2 * DIV_B) begin errors++; $display("[TB] FAIL slow_sclk_period got %0d..%0d exp %0d", minGap, maxGap, 2 * DIV_B); end
      checks++; if (falls != 16) begin errors++; $display("[TB] FAIL slow_sclk_falls got %0d exp 16", falls); end
      checks++; if (busyCyc != 32 * DIV_B + Q_B) begin errors++; $display("[TB] FAIL slow_busy got %0d exp %0d", busyCyc, 32 * DIV_B + Q_B); end
      checks++; if (doVal !== word[11:0] || errVal !== 1'b0) begin errors++; $display("[TB] FAIL slow_data got do=%h err=%b exp %h/0", doVal, errVal, word[11:0]); end
   endtask

   task automatic test_reset_mid_frame();
      int lat, okCnt, ncsLow, falls, minGap, maxGap, busyCyc, okSeen, ncsSeen;
      logic [11:0] doVal; logic errVal; bit to;
      logic [15:0] word;
      runFrame(1'b0, 16'h0ABC, lat, okCnt, ncsLow, falls, minGap, maxGap, busyCyc, doVal, errVal, to);
      checks++; if (to || doVal !== 12'hABC) begin errors++; $display("[TB] FAIL pre_abort_do got %h exp abc", doVal); end
      wordA = 16'h0777;
      okSeen = 0;
      @(posedge clk); #1 stA = 1'b1;
      @(posedge clk); #1 stA = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk); #1;
         if (okA) okSeen++;
      end
      checks++; if (ncsA !== 1'b0) begin errors++; $display("[TB] FAIL abort_in_frame got ncs=%b exp 0", ncsA); end
      #2 nrst = 1'b0;
      #1;
      checks++; if (ncsA !== 1'b1 || sclkA !== 1'b1) begin errors++; $display("[TB] FAIL abort_lines got ncs=%b sclk=%b exp 1/1", ncsA, sclkA); end
      checks++; if (doA !== 12'h000 || busyA !== 1'b0 || okA !== 1'b0) begin errors++; $display("[TB] FAIL abort_regs got do=%h busy=%b ok=%b exp 000/0/0", doA, busyA, okA); end
      repeat (3) @(posedge clk);
      @(negedge clk) nrst = 1'b1;
      ncsSeen = 0;
      for (int n = 0; n < 40; n++) begin
         @(posedge clk); #1;
         if (okA) okSeen++;
         if (!ncsA) ncsSeen++;
      end
      checks++; if (okSeen != 0) begin errors++; $display("[TB] FAIL abort_no_ok got %0d exp 0", okSeen); end
      checks++; if (ncsSeen != 0 || doA !== 12'h000) begin errors++; $display("[TB] FAIL abort_idle got ncs_low=%0d do=%h exp 0/000", ncsSeen, doA); end
      word = {4'h0, 12'($urandom)};
      runFrame(1'b0, word, lat, okCnt, ncsLow, falls, minGap, maxGap, busyCyc, doVal, errVal, to);
      checks++; if (to || lat != 1 + 32 * DIV_A || falls != 16) begin errors++; $display("[TB] FAIL after_abort_frame got lat=%0d falls=%0d exp %0d/16", lat, falls, 1 + 32 * DIV_A); end
      checks++; if (doVal !== word[11:0] || errVal !== 1'b0) begin errors++; $display("[TB] FAIL after_abort_data got do=%h err=%b exp %h/0", doVal, errVal, word[11:0]); end
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog got no completion exp finish within time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      nrst = 1'b0; stA = 1'b0; stB = 1'b0; sdataA = 1'b0; sdataB = 1'b0;
      wordA = '0; wordB = '0; idxA = 0; idxB = 0;
      test_reset();
      test_single_frame();
      test_frame_error();
      test_back_to_back();
      test_slow_config();
      test_reset_mid_frame();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
